rr_arbiter_4: RTL and testbench



---
 rtl/arb_pkg.sv | 18 +
 rtl/rr_pick4.sv | 36 +++
 rtl/rr_arbiter_4.sv | 117 +++++++++++
 tb/tb_rr_arbiter_4.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the 4-way round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational rotating-priority picker. Returns the first
//                set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import arb_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0] req,
  input  logic [ARB_IDX_W-1:0]   ptr,
  output logic [ARB_IDX_W-1:0]   pick_idx,
  output logic                   pick_any
);

  logic [ARB_IDX_W-1:0]   cand [ARB_NUM_REQ];
  logic [ARB_NUM_REQ-1:0] hit;

  // Candidate k is the requester at search position k; index wraps naturally
  for (genvar k = 0; k < ARB_NUM_REQ; k++) begin : g_cand
    assign cand[k] = ptr + ARB_IDX_W'(k);
    assign hit[k]  = req[cand[k]];
  end

  // Scan from the lowest priority upwards so the earliest search position wins
  always_comb begin
    pick_idx = ptr;
    pick_any = |req;
    for (int k = ARB_NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) pick_idx = cand[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Four-requester round-robin arbiter with registered grant
//                index/valid, owner release, and optional hold timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ARB_NUM_REQ-1:0] req,
  input  logic                   done,
  output logic [ARB_IDX_W-1:0]   grant_idx,
  output logic                   grant_valid,
  output logic                   timeout,
  output logic                   busy
);

  localparam int CNT_W_RAW = $clog2(MAX_HOLD + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  arb_state_t           state, state_next;
  logic [ARB_IDX_W-1:0] ptr, ptr_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [ARB_IDX_W-1:0] grant_idx_next;
  logic                 grant_valid_next;
  logic                 timeout_next;

  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 pick_any;
  logic                 rel_owner;
  logic                 rel_hold;
  logic                 rel_any;

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Owner-driven release (done or dropped request) outranks the hold timeout
  assign rel_owner = done | ~req[grant_idx];
  assign rel_hold  = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
  assign rel_any   = rel_owner | rel_hold;

  assign busy = grant_valid;

  // State register plus all datapath/output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cnt         <= cnt_next;
      grant_idx   <= grant_idx_next;
      grant_valid <= grant_valid_next;
      timeout     <= timeout_next;
    end
  end

  // Next-state: IDLE -> GRANT on any request, GRANT -> IDLE on any release
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = GRANT;
      GRANT:   if (rel_any)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; grant_idx is only loaded from IDLE so it
  // cannot move while a grant is active
  always_comb begin
    ptr_next         = ptr;
    cnt_next         = cnt;
    grant_idx_next   = grant_idx;
    grant_valid_next = grant_valid;
    timeout_next     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_idx_next   = pick_idx;
          grant_valid_next = 1'b1;
          cnt_next         = '0;
        end
      end
      GRANT: begin
        if (rel_any) begin
          grant_valid_next = 1'b0;
          ptr_next         = grant_idx + ARB_IDX_W'(1);
          timeout_next     = rel_hold & ~rel_owner;
        end else if (cnt != CNT_SAT) begin
          // Saturate so an unbounded hold (MAX_HOLD = 0) never wraps
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        grant_valid_next = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4
//  Description : Self-checking bench for rr_arbiter_4 (MAX_HOLD = 4) using a
//                behavioural model and an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] idx;
    logic       valid;
    logic       to;
    logic [1:0] ptr;
  } exp_t;

  exp_t sb[$];

  // Behavioural reference state
  logic [1:0] m_idx;
  logic       m_valid;
  logic       m_to;
  logic [1:0] m_ptr;
  int         m_cnt;

  rr_arbiter_4 #(.MAX_HOLD(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_idx   = 2'd0;
    m_valid = 1'b0;
    m_to    = 1'b0;
    m_ptr   = 2'd0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    logic found;
    logic own_rel;
    logic hold_rel;
    int   i;
    found = 1'b0;
    if (!m_valid) begin
      m_to = 1'b0;
      for (int k = 0; k < 4; k++) begin
        i = (int'(m_ptr) + k) % 4;
        if (!found && r[i]) begin
          found   = 1'b1;
          m_idx   = 2'(i);
          m_valid = 1'b1;
          m_cnt   = 0;
        end
      end
    end else begin
      own_rel  = d || !r[m_idx];
      hold_rel = (m_cnt == HOLD - 1);
      if (own_rel || hold_rel) begin
        m_valid = 1'b0;
        m_ptr   = 2'((int'(m_idx) + 1) % 4);
        m_to    = hold_rel && !own_rel;
      end else begin
        m_cnt++;
        m_to = 1'b0;
      end
    end
  endfunction

  // One clock: drive at negedge, queue the model prediction, compare after posedge
  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
    e.idx   = m_idx;
    e.valid = m_valid;
    e.to    = m_to;
    e.ptr   = m_ptr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("grant_idx",   32'(grant_idx),   32'(e.idx));
    check("grant_valid", 32'(grant_valid), 32'(e.valid));
    check("timeout",     32'(timeout),     32'(e.to));
    check("busy",        32'(busy),        32'(e.valid));
    check("ptr",         32'(dut.ptr),     32'(e.ptr));
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge
  task automatic async_reset(input string tag);
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #1;
    check({tag, "_idx"},     32'(grant_idx),   32'd0);
    check({tag, "_valid"},   32'(grant_valid), 32'd0);
    check({tag, "_timeout"}, 32'(timeout),     32'd0);
    check({tag, "_busy"},    32'(busy),        32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_idx",     32'(grant_idx),   32'd0);
    check("rst_valid",   32'(grant_valid), 32'd0);
    check("rst_timeout", 32'(timeout),     32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Grant 1, release with done, re-grant 3
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b0);
    check("regrant_to_3", 32'(grant_idx), 32'd3);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Full rotation with done on each grant
    #1 async_reset("rot_rst");
    for (int n = 0; n < 5; n++) begin
      step(4'b1111, 1'b0);
      check("rot_order", 32'(grant_idx), 32'(n % 4));
      step(4'b1111, 1'b1);
    end

    // Hold timeout on a single steady requester
    for (int n = 0; n < 12; n++) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);

    // done coincides with the last hold cycle: no timeout
    step(4'b0100, 1'b0);
    repeat (HOLD - 1) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    check("done_at_limit_to", 32'(timeout), 32'd0);
    step(4'b0000, 1'b0);

    // Owner drops its request mid-grant
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // Non-owner request changes during a grant are ignored
    step(4'b1000, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1001, 1'b0);

    // Reset in the middle of a grant, then search restarts at requester 0
    async_reset("mid_rst");
    step(4'b1001, 1'b0);
    check("post_rst_grant", 32'(grant_idx), 32'd0);
    step(4'b1001, 1'b1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
